// File: rtl/dot_accum_pkg.sv
// dot_accum_pkg: shared types and helpers for the dot-product accumulator.
//   state_e   : block FSM states (ACC collects beats, DONE holds a result)
//   PROD_W    : width of one incoming product
//   MIN_ACC_W : narrowest legal accumulator (must hold one full product)
//   cnt_w()   : beat counter width for a given block length
package dot_accum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int PROD_W    = 16;
  localparam int MIN_ACC_W = 16;

  function automatic int cnt_w(input int len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/dot_accum_sat_add.sv
// sat_add: combinational saturating adder, W-bit accumulator plus 16-bit
// unsigned operand.
//   a   [W-1:0] in  running sum
//   b   [15:0]  in  product to add
//   sum [W-1:0] out min(a + b, 2^W - 1)
//   ovf         out 1 when the true sum did not fit in W bits
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [15:0]  b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  // One extra bit catches the carry out; W >= 16 keeps the pad width positive.
  logic [W:0] full;

  assign full = {1'b0, a} + {{(W + 1 - 16){1'b0}}, b};
  assign ovf  = full[W];
  assign sum  = ovf ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/dot_accum.sv
// dot_accum: sums blocks of LEN unsigned 16-bit products into a saturating
// ACC_W-bit accumulator and presents each block sum on a valid/ready port.
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                abort the partial block (ignored while a result waits)
//   in_valid/in_ready  product handshake; in_ready depends on state only
//   in_prod [15:0]     product beat
//   out_valid/out_ready result handshake
//   out_sum [ACC_W-1:0] saturated block sum
//   out_ovf            saturation happened somewhere in the block
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int            CW   = cnt_w(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
    $error("dot_accum: ACC_W must be at least 16");
  end
  if (LEN < 2 || LEN > 256) begin : g_bad_len
    $error("dot_accum: LEN must be in 2..256");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             first;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             blk_ovf;

  // First beat of a block loads the product directly: feed zero to the adder
  // and ignore whatever overflow history the previous block left behind.
  assign first   = (cnt_q == '0);
  assign add_a   = first ? '0 : acc_q;
  assign blk_ovf = (first ? 1'b0 : ovf_q) | add_ovf;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (add_a),
    .b   (in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      ACC: begin
        if (clr) begin
          // Abort wins over a same-cycle beat; acc is reloaded on the next
          // first beat so it needs no clearing here.
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          acc_d = add_sum;
          ovf_d = blk_ovf;
          if (cnt_q == LAST) begin
            cnt_d       = '0;
            out_sum_d   = add_sum;
            out_ovf_d   = blk_ovf;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
          state_d     = ACC;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_dot_accum.sv
module tb_dot_accum;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [23:0] a_out_sum;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [16:0] b_out_sum;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [23:0] c_out_sum;

  int total = 0;
  int bad   = 0;

  // u_a and u_b share every input and have the same LEN, so they step in
  // lockstep; u_b exposes the narrow-accumulator saturation behaviour.
  dot_accum #(.LEN(4), .ACC_W(24)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_prod(in_prod), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf));

  dot_accum #(.LEN(4), .ACC_W(17)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_prod(in_prod), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf));

  dot_accum #(.LEN(16), .ACC_W(24)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_prod(in_prod), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_sum(c_out_sum), .out_ovf(c_out_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to u_a/u_b and hold it until accepted.
  task automatic drive_beat(input logic [15:0] p);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_prod  = p;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = a_in_ready;
      cyc();
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout prod=%h not accepted in 50 cycles", p);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    total++; if (a_out_sum !== 24'h0) begin bad++; $display("FAIL rst_out_sum got=%h exp=000000", a_out_sum); end
    total++; if (a_out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%b exp=0", a_out_ovf); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
    total++; if (c_out_valid !== 1'b0 || c_out_sum !== 24'h0) begin bad++; $display("FAIL rst_c_out got=%b/%h exp=0/000000", c_out_valid, c_out_sum); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(16'h0010);
    drive_beat(16'h0020);
    drive_beat(16'h0030);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", a_out_valid); end
    drive_beat(16'h0040);
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", a_out_valid); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL basic_bubble got=%b exp=0", a_in_ready); end
    total++; if (a_out_sum !== 24'h0000A0) begin bad++; $display("FAIL basic_sum got=%h exp=0000a0", a_out_sum); end
    total++; if (a_out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", a_out_ovf); end
    cyc();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    repeat (4) drive_beat(16'hFFFF);
    total++; if (b_out_sum !== 17'h1FFFF) begin bad++; $display("FAIL sat_sum got=%h exp=1ffff", b_out_sum); end
    total++; if (b_out_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", b_out_ovf); end
    total++; if (a_out_sum !== 24'h03FFFC || a_out_ovf !== 1'b0) begin bad++; $display("FAIL sat_wide got=%h/%b exp=03fffc/0", a_out_sum, a_out_ovf); end
    cyc();
    repeat (4) drive_beat(16'h0001);
    total++; if (b_out_sum !== 17'h00004) begin bad++; $display("FAIL sat_next_sum got=%h exp=00004", b_out_sum); end
    total++; if (b_out_ovf !== 1'b0) begin bad++; $display("FAIL sat_next_ovf got=%b exp=0", b_out_ovf); end
    cyc();
    // Landing exactly on 2^17-1 is not an overflow; one more is.
    drive_beat(16'hFFFF); drive_beat(16'hFFFF); drive_beat(16'h0001); drive_beat(16'h0000);
    total++; if (b_out_sum !== 17'h1FFFF || b_out_ovf !== 1'b0) begin bad++; $display("FAIL sat_edge_max got=%h/%b exp=1ffff/0", b_out_sum, b_out_ovf); end
    cyc();
    drive_beat(16'hFFFF); drive_beat(16'hFFFF); drive_beat(16'h0002); drive_beat(16'h0000);
    total++; if (b_out_sum !== 17'h1FFFF || b_out_ovf !== 1'b1) begin bad++; $display("FAIL sat_edge_over got=%h/%b exp=1ffff/1", b_out_sum, b_out_ovf); end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(16'h0001); drive_beat(16'h0002); drive_beat(16'h0003); drive_beat(16'h0004);
    in_valid = 1'b1;
    in_prod  = 16'h0007;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 24'h00000A || a_out_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b sum=%h ovf=%b rdy=%b exp v=1 sum=00000a ovf=0 rdy=0",
                 i, a_out_valid, a_out_sum, a_out_ovf, a_in_ready);
      end
    end
    out_ready = 1'b1;
    cyc();
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_handshake got v=%b rdy=%b exp v=0 rdy=1", a_out_valid, a_in_ready); end
    cyc();
    in_valid = 1'b0;
    drive_beat(16'h0002); drive_beat(16'h0002); drive_beat(16'h0002);
    total++; if (a_out_valid !== 1'b1 || a_out_sum !== 24'h00000D) begin bad++; $display("FAIL bp_held_beat got v=%b sum=%h exp v=1 sum=00000d", a_out_valid, a_out_sum); end
    cyc();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    drive_beat(16'h0100);
    drive_beat(16'h0200);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'h0050;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    repeat (4) drive_beat(16'h0001);
    total++; if (a_out_sum !== 24'h000004 || a_out_ovf !== 1'b0) begin bad++; $display("FAIL clr_acc_sum got=%h/%b exp=000004/0", a_out_sum, a_out_ovf); end
    cyc();
    out_ready = 1'b0;
    drive_beat(16'h0005); drive_beat(16'h0006); drive_beat(16'h0007); drive_beat(16'h0008);
    clr = 1'b1;
    repeat (2) cyc();
    total++; if (a_out_valid !== 1'b1 || a_out_sum !== 24'h00001A) begin bad++; $display("FAIL clr_done_kept got v=%b sum=%h exp v=1 sum=00001a", a_out_valid, a_out_sum); end
    clr = 1'b0;
    out_ready = 1'b1;
    cyc();
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL clr_done_release got v=%b rdy=%b exp v=0 rdy=1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_beat(16'h0003);
    drive_beat(16'h0003);
    rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_out_sum !== 24'h0 || a_out_ovf !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_outputs got v=%b sum=%h ovf=%b rdy=%b exp 0/000000/0/1", a_out_valid, a_out_sum, a_out_ovf, a_in_ready); end
    cyc();
    rst_n = 1'b1;
    repeat (4) drive_beat(16'h0005);
    total++; if (a_out_valid !== 1'b1 || a_out_sum !== 24'h000014) begin bad++; $display("FAIL rstmid_block got v=%b sum=%h exp v=1 sum=000014", a_out_valid, a_out_sum); end
    cyc();
    out_ready = 1'b0;
    repeat (4) drive_beat(16'h0009);
    rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_out_sum !== 24'h0 || a_out_ovf !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL rstdone_outputs got v=%b sum=%h ovf=%b rdy=%b exp 0/000000/0/1", a_out_valid, a_out_sum, a_out_ovf, a_in_ready); end
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) drive_beat(16'h0005);
    total++; if (a_out_valid !== 1'b1 || a_out_sum !== 24'h000014) begin bad++; $display("FAIL rstdone_block got v=%b sum=%h exp v=1 sum=000014", a_out_valid, a_out_sum); end
    cyc();
  endtask

  task automatic test_random_stream();
    logic [23:0] exp_q[$];
    logic [24:0] msum;
    logic [23:0] obs_sum, exp_sum;
    logic        obs_ovf, acc, hs;
    int          mcnt;
    int          nchk;
    do_reset();
    msum = '0; mcnt = 0; nchk = 0;
    for (int n = 0; n < 4000 && nchk < 6; n++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_prod  = 16'($urandom_range(0, 65535));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc     = in_valid & c_in_ready;
      hs      = c_out_valid & out_ready;
      obs_sum = c_out_sum;
      obs_ovf = c_out_ovf;
      cyc();
      if (hs) begin
        nchk++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected_result got=%h exp=none", obs_sum);
        end else begin
          exp_sum = exp_q.pop_front();
          if (obs_sum !== exp_sum || obs_ovf !== 1'b0) begin
            bad++;
            $display("FAIL rand_sum blk=%0d got=%h/%b exp=%h/0", nchk, obs_sum, obs_ovf, exp_sum);
          end
        end
      end
      if (acc) begin
        msum = msum + {9'b0, in_prod};
        mcnt++;
        in_valid = 1'b0;
        if (mcnt == 16) begin
          exp_q.push_back(msum > 25'hFFFFFF ? 24'hFFFFFF : msum[23:0]);
          msum = '0;
          mcnt = 0;
        end
      end
    end
    in_valid = 1'b0;
    if (nchk < 6) begin
      total++; bad++;
      $display("FAIL rand_timeout got=%0d blocks exp=6", nchk);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
